// File: rtl/sdram_cmd_responder.sv
// rtl/sdram_cmd_responder.sv - SDRAM command-bus responder: protocol checker, bank tracker and 64x16 memory model (optional SDRAM_RSP_REFWDOG_EN refresh watchdog)
module sdram_cmd_responder #(
    parameter int CAS_LAT      = 2,
    parameter int TRCD         = 2,
    parameter int REF_INTERVAL = 140,
    parameter int INIT_REFS    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  command_i,
    input  logic [1:0]  bank_i,
    input  logic [11:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        rvalid_o,
    output logic        init_done_o,
    output logic [3:0]  bank_open_o,
    output logic        err_o,
    output logic [3:0]  err_code_o
);

    localparam logic [3:0] C_DESL  = 4'h0;
    localparam logic [3:0] C_NOP   = 4'h1;
    localparam logic [3:0] C_MRS   = 4'h2;
    localparam logic [3:0] C_ACT   = 4'h3;
    localparam logic [3:0] C_READ  = 4'h4;
    localparam logic [3:0] C_READA = 4'h5;
    localparam logic [3:0] C_WRIT  = 4'h6;
    localparam logic [3:0] C_WRITA = 4'h7;
    localparam logic [3:0] C_PRE   = 4'h8;
    localparam logic [3:0] C_PALL  = 4'h9;
    localparam logic [3:0] C_REF   = 4'hB;
    localparam logic [3:0] C_SELF  = 4'hC;
    localparam logic [3:0] C_SUP   = 4'hD;
    localparam logic [3:0] C_REC   = 4'hE;
    localparam logic [3:0] C_NOPF  = 4'hF;

    localparam logic [3:0] E_STATE     = 4'd1;
    localparam logic [3:0] E_ACT_OPEN  = 4'd2;
    localparam logic [3:0] E_CLOSED    = 4'd3;
    localparam logic [3:0] E_TRCD      = 4'd4;
    localparam logic [3:0] E_REF_OPEN  = 4'd5;
    localparam logic [3:0] E_WDOG      = 4'd6;
    localparam logic [3:0] E_LOWPWR    = 4'd7;
    localparam logic [3:0] E_EARLY_MRS = 4'd8;

    localparam int RW = $clog2(INIT_REFS + 2);

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_PRECHG,
        ST_READY,
        ST_SELF,
        ST_PDOWN
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      ref_cnt_q;
    logic [3:0]         bank_open_q;
    logic [11:0]        row_q [4];
    logic [3:0]         trcd_q [4];
    logic               err_q;
    logic [3:0]         err_code_q;
    logic               init_done_q;
    logic [CAS_LAT-1:0] pv_q;
    logic [15:0]        pd_q [CAS_LAT];
    logic [15:0]        mem [64];

    logic [3:0] viol;
    logic [3:0] event_code;
    logic       is_idle;
    logic       is_rw;
    logic       sel_open;
    logic       rd_go;
    logic       wr_go;
    logic       wdog_trip;
    logic [5:0] mem_idx;

    assign mem_idx = {bank_i, addr_i[3:0]};

    // Open rows are tracked per bank but nothing in this model consumes them yet.
    logic unused_rows;
    assign unused_rows = ^{row_q[0], row_q[1], row_q[2], row_q[3]};

    // Classify the incoming command: violation code, next state and data-path strobes.
    always_comb begin
        viol     = 4'd0;
        state_d  = state_q;
        is_idle  = (command_i == C_DESL) || (command_i == C_NOP) || (command_i == C_NOPF);
        is_rw    = (command_i == C_READ) || (command_i == C_READA) ||
                   (command_i == C_WRIT) || (command_i == C_WRITA);
        sel_open = bank_open_q[bank_i];
        case (state_q)
            ST_UNINIT: begin
                if (!is_idle && command_i != C_PALL) viol = E_STATE;
                else if (command_i == C_PALL)        state_d = ST_PRECHG;
            end
            ST_PRECHG: begin
                if (command_i == C_MRS && ref_cnt_q < RW'(INIT_REFS))     viol = E_EARLY_MRS;
                else if (!is_idle && command_i != C_REF && command_i != C_MRS) viol = E_STATE;
                else if (command_i == C_MRS)                               state_d = ST_READY;
            end
            ST_READY: begin
                if (command_i == C_ACT && sel_open)                              viol = E_ACT_OPEN;
                else if (is_rw && !sel_open)                                     viol = E_CLOSED;
                else if (is_rw && trcd_q[bank_i] != 4'd0)                        viol = E_TRCD;
                else if ((command_i == C_REF || command_i == C_SELF) && |bank_open_q) viol = E_REF_OPEN;
                else if (command_i == C_SELF)                                    state_d = ST_SELF;
                else if (command_i == C_SUP)                                     state_d = ST_PDOWN;
            end
            ST_SELF: begin
                if (!is_idle)                                        viol = E_LOWPWR;
                else if (command_i == C_NOP || command_i == C_NOPF)  state_d = ST_READY;
            end
            ST_PDOWN: begin
                if (!is_idle && command_i != C_REC) viol = E_LOWPWR;
                else if (command_i == C_REC)        state_d = ST_READY;
            end
            default: state_d = ST_UNINIT;
        endcase
        rd_go      = (state_q == ST_READY) && (viol == 4'd0) &&
                     ((command_i == C_READ) || (command_i == C_READA));
        wr_go      = (state_q == ST_READY) && (viol == 4'd0) &&
                     ((command_i == C_WRIT) || (command_i == C_WRITA));
        event_code = (viol != 4'd0) ? viol : (wdog_trip ? E_WDOG : 4'd0);
    end

`ifdef SDRAM_RSP_REFWDOG_EN
    localparam int WW = $clog2(REF_INTERVAL + 2);
    logic [WW-1:0] wdog_q;

    assign wdog_trip = ((state_q == ST_READY) || (state_q == ST_PDOWN)) &&
                       (wdog_q > WW'(REF_INTERVAL));

    // Refresh watchdog: restarts on REF or READY entry, holds in SELF, saturates instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else if ((state_d == ST_READY && state_q != ST_READY) ||
                     (state_q == ST_READY && command_i == C_REF && viol == 4'd0)) begin
            wdog_q <= '0;
        end else if ((state_q == ST_READY || state_q == ST_PDOWN) && wdog_q != '1) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

    // Top-level FSM, bank bookkeeping and sticky first-error capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_UNINIT;
            ref_cnt_q   <= '0;
            bank_open_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 4'd0;
            init_done_q <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d != ST_UNINIT) && (state_d != ST_PRECHG);
            for (int b = 0; b < 4; b++) begin
                if (trcd_q[b] != 4'd0) trcd_q[b] <= trcd_q[b] - 4'd1;
            end
            if (!err_q && event_code != 4'd0) begin
                err_q      <= 1'b1;
                err_code_q <= event_code;
            end
            if (viol == 4'd0) begin
                case (state_q)
                    ST_UNINIT: begin
                        if (command_i == C_PALL) begin
                            bank_open_q <= '0;
                            ref_cnt_q   <= '0;
                        end
                    end
                    ST_PRECHG: begin
                        if (command_i == C_REF && ref_cnt_q < RW'(INIT_REFS))
                            ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                    ST_READY: begin
                        case (command_i)
                            C_ACT: begin
                                bank_open_q[bank_i] <= 1'b1;
                                row_q[bank_i]       <= addr_i;
                                trcd_q[bank_i]      <= 4'(TRCD - 1);
                            end
                            C_READA, C_WRITA, C_PRE: bank_open_q[bank_i] <= 1'b0;
                            C_PALL:                  bank_open_q         <= '0;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read return pipeline: one stage per CAS cycle, data forced to zero when not valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pv_q <= '0;
            for (int i = 0; i < CAS_LAT; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= rd_go;
            pd_q[0] <= rd_go ? mem[mem_idx] : 16'h0000;
            for (int i = 1; i < CAS_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    // Storage array is not reset; writes land in the command cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_go) mem[mem_idx] <= wdata_i;
    end

    assign rdata_o     = pd_q[CAS_LAT-1];
    assign rvalid_o    = pv_q[CAS_LAT-1];
    assign init_done_o = init_done_q;
    assign bank_open_o = bank_open_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb/tb_sdram_cmd_responder.sv - directed scoreboard bench for sdram_cmd_responder
module tb_sdram_cmd_responder;

    localparam int CL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  command = 4'h1;
    logic [1:0]  bank = 2'd0;
    logic [11:0] addr = 12'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        rvalid;
    logic        init_done;
    logic [3:0]  bank_open;
    logic        err;
    logic [3:0]  err_code;

    sdram_cmd_responder #(.CAS_LAT(CL), .TRCD(2), .REF_INTERVAL(140), .INIT_REFS(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .command_i   (command),
        .bank_i      (bank),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .init_done_o (init_done),
        .bank_open_o (bank_open),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;
    rd_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
        command = c;
        bank    = b;
        addr    = a;
        wdata   = d;
        @(posedge clk);
        @(negedge clk);
        command = 4'h1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(4'h1, 2'd0, 12'd0, 16'd0);
    endtask

    task automatic rd_exp(input logic [1:0] b, input logic [3:0] col, input logic [15:0] d, input bit auto_pre);
        rd_t e;
        e.due  = cyc + CL;
        e.data = d;
        sb.push_back(e);
        issue(auto_pre ? 4'h5 : 4'h4, b, {8'h00, col}, 16'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        command = 4'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_init();
        nops(3);
        issue(4'h9, 2'd0, 12'd0, 16'd0);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'h2, 2'd0, 12'd0, 16'd0);
    endtask

    // Read-return monitor: every cycle rvalid must match the scoreboard head's due cycle.
    always @(negedge clk) begin : mon
        rd_t e;
        bit  exp_v;
        if (mon_en) begin
            exp_v = (sb.size() != 0) && (sb[0].due == cyc);
            chk("rvalid", {31'd0, rvalid}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                chk("rdata", {16'd0, rdata}, {16'd0, e.data});
            end else begin
                chk("rdata_idle", {16'd0, rdata}, 32'd0);
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_bank_open", {28'd0, bank_open}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {28'd0, err_code}, 32'd0);

        // init sequence
        nops(3);
        issue(4'h9, 2'd0, 12'd0, 16'd0);
        chk("prechg_init_done", {31'd0, init_done}, 32'd0);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'h2, 2'd0, 12'd0, 16'd0);
        chk("init_done", {31'd0, init_done}, 32'd1);
        chk("init_err", {31'd0, err}, 32'd0);

        // write then auto-precharge read
        issue(4'h3, 2'd1, 12'd5, 16'd0);
        chk("act_b1_open", {28'd0, bank_open}, 32'h2);
        nops(1);
        issue(4'h6, 2'd1, 12'd3, 16'hBEEF);
        rd_exp(2'd1, 4'd3, 16'hBEEF, 1'b1);
        chk("reada_closes", {28'd0, bank_open}, 32'h0);
        nops(3);

        // back-to-back reads, write-then-read at the top address
        issue(4'h3, 2'd3, 12'h0AB, 16'd0);
        nops(1);
        for (int i = 0; i < 4; i++) issue(4'h6, 2'd3, 12'(i), 16'h1000 + 16'(i * 16'h0111));
        for (int i = 0; i < 4; i++) rd_exp(2'd3, 4'(i), 16'h1000 + 16'(i * 16'h0111), 1'b0);
        issue(4'h6, 2'd3, 12'd15, 16'hA5A5);
        rd_exp(2'd3, 4'd15, 16'hA5A5, 1'b0);
        nops(3);
        issue(4'h8, 2'd3, 12'd0, 16'd0);
        chk("pre_closes", {28'd0, bank_open}, 32'h0);
        issue(4'h8, 2'd3, 12'd0, 16'd0);
        issue(4'h9, 2'd0, 12'd0, 16'd0);
        chk("pre_closed_legal", {31'd0, err}, 32'd0);

        // low-power entry/exit
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'hC, 2'd0, 12'd0, 16'd0);
        chk("self_init_done", {31'd0, init_done}, 32'd1);
        issue(4'h0, 2'd0, 12'd0, 16'd0);
        issue(4'h1, 2'd0, 12'd0, 16'd0);
        issue(4'hD, 2'd0, 12'd0, 16'd0);
        issue(4'hE, 2'd0, 12'd0, 16'd0);
        chk("lowpwr_err", {31'd0, err}, 32'd0);

        // refresh watchdog
        nops(150);
`ifdef SDRAM_RSP_REFWDOG_EN
        chk("wdog_code", {28'd0, err_code}, 32'd6);
`else
        chk("wdog_absent_err", {31'd0, err}, 32'd0);
        chk("wdog_absent_code", {28'd0, err_code}, 32'd0);
`endif

        // tRCD violation, sticky code, violating write has no effect
        do_reset();
        do_init();
        issue(4'h3, 2'd2, 12'd7, 16'd0);
        issue(4'h4, 2'd2, 12'd0, 16'd0);
        chk("trcd_err", {31'd0, err}, 32'd1);
        chk("trcd_code", {28'd0, err_code}, 32'd4);
        nops(1);
        issue(4'h3, 2'd0, 12'd1, 16'd0);
        chk("sticky_after_act", {28'd0, err_code}, 32'd4);
        chk("banks_after_act", {28'd0, bank_open}, 32'h5);
        issue(4'h3, 2'd2, 12'd9, 16'd0);
        chk("sticky_after_viol", {28'd0, err_code}, 32'd4);
        issue(4'h6, 2'd1, 12'd3, 16'hDEAD);
        issue(4'h3, 2'd1, 12'd5, 16'd0);
        nops(1);
        rd_exp(2'd1, 4'd3, 16'hBEEF, 1'b0);
        nops(3);

        // early MRS
        do_reset();
        chk("rst2_init_done", {31'd0, init_done}, 32'd0);
        issue(4'h9, 2'd0, 12'd0, 16'd0);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        issue(4'h2, 2'd0, 12'd0, 16'd0);
        chk("early_mrs_err", {31'd0, err}, 32'd1);
        chk("early_mrs_code", {28'd0, err_code}, 32'd8);
        chk("early_mrs_init", {31'd0, init_done}, 32'd0);

        // command in UNINIT
        do_reset();
        issue(4'h3, 2'd0, 12'd0, 16'd0);
        chk("uninit_code", {28'd0, err_code}, 32'd1);
        chk("uninit_no_open", {28'd0, bank_open}, 32'h0);

        // command in SELF
        do_reset();
        do_init();
        issue(4'hC, 2'd0, 12'd0, 16'd0);
        issue(4'h3, 2'd0, 12'd0, 16'd0);
        chk("self_code", {28'd0, err_code}, 32'd7);
        chk("self_no_open", {28'd0, bank_open}, 32'h0);

        // REF with an open bank
        do_reset();
        do_init();
        issue(4'h3, 2'd0, 12'd0, 16'd0);
        nops(1);
        issue(4'hB, 2'd0, 12'd0, 16'd0);
        chk("ref_open_code", {28'd0, err_code}, 32'd5);

        // reset during CAS latency
        do_reset();
        do_init();
        issue(4'h3, 2'd1, 12'd5, 16'd0);
        nops(1);
        issue(4'h4, 2'd1, 12'd3, 16'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstcas_bank_open", {28'd0, bank_open}, 32'h0);
        chk("rstcas_init_done", {31'd0, init_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nops(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_responder.md
SDRAM_CMD_RESPONDER -- requirements
Module: sdram_cmd_responder

Interface
REQ-001 Parameter CAS_LAT, default 2, cycles from READ/READA accept to rdata valid (range 1..3).
REQ-002 Parameter TRCD, default 2, minimum cycles from ACT to READ/WRIT on the same bank.
REQ-003 Parameter REF_INTERVAL, default 140, maximum cycles between REF commands once ready.
REQ-004 Parameter INIT_REFS, default 2, REF commands required between PALL and MRS at init.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 command  in  4  controller command code, sampled every cycle.
REQ-008 bank  in  2  target bank for ACT/READ/READA/WRIT/WRITA/PRE.
REQ-009 addr  in  12  row for ACT; addr[3:0] is the column for READ/WRIT.
REQ-010 wdata  in  16  write data, sampled in the same cycle as WRIT/WRITA.
REQ-011 rdata  out  16  read data; 0 when rvalid=0.
REQ-012 rvalid  out  1  rdata valid strobe, one cycle per read.
REQ-013 init_done  out  1  init sequence complete.
REQ-014 bank_open  out  4  per-bank active flag.
REQ-015 err  out  1  sticky protocol-violation flag.
REQ-016 err_code  out  4  code of the first violation; 0 = none.

Function
REQ-017 Codes SHALL decode as: 0 DESL, 1 NOP, 2 MRS, 3 ACT, 4 READ, 5 READA, 6 WRIT, 7 WRITA, 8 PRE, 9 PALL, A BST, B REF, C SELF, D SUP, E REC, F treated as NOP.
REQ-018 The top-level FSM SHALL have the states UNINIT, PRECHG, READY, SELF and PDOWN.
- UNINIT->PRECHG on PALL.
- PRECHG->READY on MRS once at least INIT_REFS REFs have been counted.
- READY->SELF on SELF; SELF->READY on NOP.
- READY->PDOWN on SUP; PDOWN->READY on REC.
REQ-019 In UNINIT, any command except DESL/NOP/PALL SHALL raise code 1.
REQ-020 In PRECHG, an MRS received with fewer than INIT_REFS REFs SHALL raise code 8 and leave the state in PRECHG.
REQ-021 In PRECHG, any command other than DESL/NOP/REF/MRS SHALL raise code 1.
REQ-022 init_done SHALL be 1 whenever the state is not UNINIT or PRECHG.
REQ-023 Per-bank tracking SHALL hold an open flag, a 12-bit row, and a tRCD down-counter loaded with TRCD-1 on ACT.
REQ-024 ACT to an open bank SHALL raise code 2.
REQ-025 READ/READA/WRIT/WRITA to a closed bank SHALL raise code 3.
REQ-026 READ/READA/WRIT/WRITA issued while that bank's tRCD counter is non-zero SHALL raise code 4.
REQ-027 PRE SHALL close the selected bank; PALL SHALL close all banks; PRE/PALL on a closed bank is legal.
REQ-028 READA/WRITA SHALL close the bank in the cycle after the command.
REQ-029 REF or SELF with any bank open SHALL raise code 5.
REQ-030 In SELF or PDOWN, any command other than DESL, NOP, or the exit command SHALL raise code 7.
REQ-031 Storage SHALL be a 64x16 array indexed {bank, addr[3:0]}; WRIT/WRITA write wdata in the command cycle.
REQ-032 Read return SHALL use a CAS_LAT-deep pipeline: rdata/rvalid appear exactly CAS_LAT cycles after the command cycle; back-to-back reads SHALL return back-to-back.
REQ-033 A read and a write to the same address in one cycle cannot occur (single command bus); a write followed by a read returns the new data.
REQ-034 BST SHALL be accepted as a no-op (burst length 1).
REQ-035 A violating command SHALL have no other effect: no state, bank, or memory change, and no rvalid.
REQ-036 err SHALL set on the first violation; err_code SHALL capture that first code and hold until reset, with later violations ignored.

Reset
REQ-037 On rst=1 at a clock edge, the design SHALL enter UNINIT.
REQ-038 Reset SHALL clear bank_open, rows, tRCD counters, the REF count, the read pipeline, rvalid, rdata, err, err_code, init_done and the watchdog counter.
REQ-039 Array contents are not reset; an in-flight read is discarded with no rvalid.

Configuration
REQ-040 Macro SDRAM_RSP_REFWDOG_EN: when defined, a cycle counter is cleared on REF and on entry to READY, frozen in SELF, and raises code 6 when it exceeds REF_INTERVAL in READY/PDOWN; when undefined, the counter is absent and code 6 is never raised.

Verification
REQ-041 Init: NOP x3, PALL, REF, REF, MRS -> init_done=1 the cycle after MRS, err=0.
REQ-042 Early MRS: PALL, REF, MRS -> err=1, err_code=8, init_done stays 0.
REQ-043 After init: ACT b1 row 5, NOP, WRIT b1 col 3 wdata=16'hBEEF, READA b1 col 3 -> rvalid with rdata=16'hBEEF 2 cycles after READA, and bank_open[1]=0 afterwards.
REQ-044 ACT b2 then READ b2 on the next cycle -> err_code=4, no rvalid; a subsequent ACT b0 -> err_code stays 4.
REQ-045 With the macro defined, NOP for 141 cycles after init -> err_code=6; with the macro undefined -> err=0.
REQ-046 Assert rst during a READ's CAS latency -> no rvalid, and bank_open=0 and init_done=0 the cycle after reset.
